xip_prefetch_buffer: RTL
========================

Name: xip_prefetch_buffer

Overview:
- Single-line read prefetch buffer placed directly upstream of xip_engine's AXI-Lite read channel.
- On a miss, fetches a whole aligned line of LINE_WORDS 32-bit words from xip_engine using sequential single-word reads, then serves subsequent same-line reads locally with 1-cycle latency.
- Cuts the QSPI command/address/dummy overhead for linear code fetch. The write channel bypasses this block entirely.

Parameters:
- ADDR_W, 32, AXI address width.
- LINE_WORDS, 4, words per line; power of two, 2..16.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable_i  in  1  0 = pass-through mode (every read is forwarded, line never filled)
- invalidate_i  in  1  one-cycle pulse; drops the line (driven on XIP write or config change)
- s_araddr_i  in  ADDR_W  requester read address
- s_arvalid_i  in  1  requester read address valid
- s_arready_o  out  1  read address accepted
- s_rdata_o  out  32  read data to requester
- s_rresp_o  out  2  read response to requester
- s_rvalid_o  out  1  read data valid
- s_rready_i  in  1  requester ready for read data
- m_araddr_o  out  ADDR_W  word address to xip_engine
- m_arvalid_o  out  1  address valid to xip_engine
- m_arready_i  in  1  xip_engine address ready
- m_rdata_i  in  32  read data from xip_engine
- m_rresp_i  in  2  read response from xip_engine
- m_rvalid_i  in  1  read data valid from xip_engine
- m_rready_o  out  1  ready for xip_engine read data
- hit_o  out  1  one-cycle pulse on a lookup hit
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, line_valid=0, state IDLE.
- Address handling: araddr[1:0] ignored. tag = araddr[ADDR_W-1:log2(LINE_WORDS)+2]. Word index = next log2(LINE_WORDS) bits.
- States: IDLE, FILL_AR, FILL_R, RESP.
- IDLE:
  - s_arready_o=1.
  - On accept (cycle T), latch the address.
  - Hit (enable_i & line_valid & tag match, no invalidate_i in cycle T): load s_rdata_o from the line, rresp=00, hit_o=1; enter RESP with s_rvalid_o=1 in T+1.
  - Otherwise (miss): beat=0, enter FILL_AR.
  - In pass-through mode the fetch base is the requested word and the fill length is 1.
- FILL_AR:
  - m_arvalid_o=1, m_araddr_o = line_base + beat*4 (low 2 bits 0).
  - Hold address stable until m_arready_i; then go to FILL_R.
- FILL_R:
  - m_rready_o=1. On m_rvalid_i, store the word in line[beat] and OR m_rresp_i[1] into err.
  - Last beat (beat==LINE_WORDS-1): line_valid = ~err & ~inv_pending & enable_i; tag updated; s_rdata_o = line word for the requested index (m_rdata_i directly in pass-through); s_rresp_o = err ? 2'b10 : 2'b00; go to RESP.
  - Otherwise beat+1, back to FILL_AR.
- RESP:
  - s_rvalid_o held with stable data until s_rready_i; then back to IDLE with s_rvalid_o=0.
  - s_arready_o=0.
- One outstanding transaction on each side. The master issues at most one AR before its R.
- invalidate_i:
  - In IDLE or RESP: clears line_valid the same cycle.
  - In FILL_*: sets inv_pending. The fill completes, the pending requester still gets the fetched data, and the line stays invalid afterwards.
  - inv_pending clears on return to IDLE.
- Error in any beat: remaining beats are still fetched (keeps the engine sequence simple), the line is not marked valid, and the requester gets SLVERR.
- enable_i falling mid-fill: the fill completes and the line stays invalid.
- Simultaneous invalidate_i and hit request in the same IDLE cycle: treated as a miss.
- Reset mid-fill: returns to IDLE immediately. The bench must reset xip_engine together with this block.

Decomposition:
- xip_pkg holds: AXI resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), the state encoding localparams, and a tag/index width function.
- One natural sub-module, xip_line_store: LINE_WORDS x 32 register array with a write port (beat index, data) and a combinational read port (word index).
- The controller FSM stays in the top module.

Test Plan:
- Bench slave model returns word = addr ^ 32'hA5A5_0000 with 3-cycle latency.
- Cold read 0x0000_0008 -> 4 master reads (0x0, 0x4, 0x8, 0xC); s_rdata = 0xA5A5_0008, rresp=00, hit_o=0.
- Then reads 0x0, 0x4, 0xC -> no master traffic, hit_o pulses, data 0xA5A5_0000/0004/000C, rvalid one cycle after accept.
- Read 0x10 -> miss; 4 master reads at 0x10..0x1C; data 0xA5A5_0010; a following read of 0x0 misses again.
- Slave returns SLVERR on beat 2 of a fill for 0x20 -> s_rresp=2'b10; re-reading 0x20 refetches all 4 words.
- invalidate_i pulse during beat 1 of a fill for 0x40 -> data 0xA5A5_0040 still returned; next read 0x44 misses.
- enable_i=0, two reads of 0x4 -> each issues exactly one master read at 0x4; hit_o stays 0. s_rready_i held low 5 cycles -> s_rvalid/s_rdata stay stable.

Source files
------------

// File: rtl/xip_pkg.sv
// Shared constants for the XIP read prefetch path: AXI responses, FSM encoding, address split.
// Latency: none, declarations only.
// Backpressure: n/a.
package xip_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FILL_AR = 2'd1;
   localparam logic [1:0] ST_FILL_R  = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   // Bits selecting a word inside a line (line_words is a power of two)
   function automatic int xip_idx_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Bits left for the line tag after word index and byte offset
   function automatic int xip_tag_w(input int addr_w, input int line_words);
      return addr_w - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/xip_line_store.sv
// One prefetch line held as a small register array, written one beat at a time.
// Latency: write takes effect next cycle; read port is combinational.
// Backpressure: none, writes are accepted every cycle i_wr_en is high.
module xip_line_store
   import xip_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = xip_idx_w(LINE_WORDS)
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [31:0]      i_wr_dat,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [31:0]      o_rd_dat
);

   logic [31:0] r_words [LINE_WORDS];

   // Capture one fetched beat into its slot
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= '0;
      end else if (i_wr_en) begin
         r_words[i_wr_idx] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_words[i_rd_idx];

endmodule

// File: rtl/xip_prefetch_buffer.sv
// Single-line read prefetch in front of xip_engine: misses fetch a whole line word by word.
// Latency: hit returns data the cycle after accept; a miss costs LINE_WORDS engine reads.
// Backpressure: one transaction at a time; s_rvalid_o holds stable data until s_rready_i.
module xip_prefetch_buffer
   import xip_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable_i,
   input  logic              invalidate_i,
   input  logic [ADDR_W-1:0] s_araddr_i,
   input  logic              s_arvalid_i,
   output logic              s_arready_o,
   output logic [31:0]       s_rdata_o,
   output logic [1:0]        s_rresp_o,
   output logic              s_rvalid_o,
   input  logic              s_rready_i,
   output logic [ADDR_W-1:0] m_araddr_o,
   output logic              m_arvalid_o,
   input  logic              m_arready_i,
   input  logic [31:0]       m_rdata_i,
   input  logic [1:0]        m_rresp_i,
   input  logic              m_rvalid_i,
   output logic              m_rready_o,
   output logic              hit_o,
   output logic              busy_o
);

   localparam int IDX_W = xip_idx_w(LINE_WORDS);
   localparam int TAG_W = xip_tag_w(ADDR_W, LINE_WORDS);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

   logic [1:0]        r_state, w_next_state;
   logic              r_line_valid;
   logic [TAG_W-1:0]  r_tag, r_req_tag;
   logic [IDX_W-1:0]  r_req_idx, r_beat;
   logic [ADDR_W-1:0] r_base;
   logic              r_err, r_inv_pending, r_pass;
   logic [31:0]       r_rdata;
   logic [1:0]        r_rresp;
   logic              r_rvalid, r_hit, r_arready;

   logic [TAG_W-1:0]  w_tag_in;
   logic [IDX_W-1:0]  w_idx_in, w_rd_idx;
   logic [ADDR_W-1:0] w_beat_off;
   logic [31:0]       w_rd_word, w_fill_word;
   logic              w_accept, w_hit, w_last, w_err_any, w_wr_en, w_unused;

   assign w_tag_in   = s_araddr_i[ADDR_W-1 -: TAG_W];
   assign w_idx_in   = s_araddr_i[IDX_W+1:2];
   assign w_accept   = r_arready & s_arvalid_i;
   // An invalidate landing on the lookup cycle wins over the hit
   assign w_hit      = enable_i & r_line_valid & (w_tag_in == r_tag) & ~invalidate_i;
   // Pass-through fetches exactly one word
   assign w_last     = r_pass | (r_beat == LAST_BEAT);
   assign w_err_any  = r_err | m_rresp_i[1];
   assign w_wr_en    = (r_state == ST_FILL_R) & m_rvalid_i & ~r_pass;
   assign w_rd_idx   = (r_state == ST_IDLE) ? w_idx_in : r_req_idx;
   assign w_beat_off = {{(ADDR_W-IDX_W-2){1'b0}}, r_beat, 2'b00};
   // The requested word may be the one arriving this cycle, not yet in the store
   assign w_fill_word = (r_pass || (r_req_idx == r_beat)) ? m_rdata_i : w_rd_word;
   assign w_unused   = ^{s_araddr_i[1:0], m_rresp_i[0]};

   assign s_arready_o = r_arready;
   assign s_rdata_o   = r_rdata;
   assign s_rresp_o   = r_rresp;
   assign s_rvalid_o  = r_rvalid;
   assign hit_o       = r_hit;
   assign m_araddr_o  = r_base + w_beat_off;

   xip_line_store #(
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W)
   ) u_line_store (
      .clk      (clk),
      .resetn   (resetn),
      .i_wr_en  (w_wr_en),
      .i_wr_idx (r_beat),
      .i_wr_dat (m_rdata_i),
      .i_rd_idx (w_rd_idx),
      .o_rd_dat (w_rd_word)
   );

   // Controller state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state selection
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept)    w_next_state = w_hit ? ST_RESP : ST_FILL_AR;
         ST_FILL_AR: if (m_arready_i) w_next_state = ST_FILL_R;
         ST_FILL_R:  if (m_rvalid_i)  w_next_state = w_last ? ST_RESP : ST_FILL_AR;
         ST_RESP:    if (s_rready_i)  w_next_state = ST_IDLE;
         default:                     w_next_state = ST_IDLE;
      endcase
   end

   // Engine-side handshakes and busy flag decoded from state
   always_comb begin
      m_arvalid_o = (r_state == ST_FILL_AR);
      m_rready_o  = (r_state == ST_FILL_R);
      busy_o      = (r_state != ST_IDLE);
   end

   // Lookup, fill bookkeeping and requester response registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_arready     <= 1'b0;
         r_hit         <= 1'b0;
         r_rvalid      <= 1'b0;
         r_rdata       <= '0;
         r_rresp       <= RESP_OKAY;
         r_line_valid  <= 1'b0;
         r_tag         <= '0;
         r_req_tag     <= '0;
         r_req_idx     <= '0;
         r_beat        <= '0;
         r_base        <= '0;
         r_err         <= 1'b0;
         r_inv_pending <= 1'b0;
         r_pass        <= 1'b0;
      end else begin
         r_arready <= (w_next_state == ST_IDLE);
         r_hit     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_inv_pending <= 1'b0;
               if (invalidate_i) r_line_valid <= 1'b0;
               if (w_accept) begin
                  r_req_idx <= w_idx_in;
                  r_req_tag <= w_tag_in;
                  if (w_hit) begin
                     r_rdata  <= w_rd_word;
                     r_rresp  <= RESP_OKAY;
                     r_hit    <= 1'b1;
                     r_rvalid <= 1'b1;
                  end else begin
                     r_beat <= '0;
                     r_err  <= 1'b0;
                     r_pass <= ~enable_i;
                     r_base <= enable_i ? {w_tag_in, {(IDX_W+2){1'b0}}}
                                        : {s_araddr_i[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            ST_FILL_AR: begin
               // Enable dropping mid-fill poisons the line just like an invalidate
               if (invalidate_i | ~enable_i) r_inv_pending <= 1'b1;
            end
            ST_FILL_R: begin
               if (invalidate_i | ~enable_i) r_inv_pending <= 1'b1;
               if (m_rvalid_i) begin
                  r_err <= w_err_any;
                  if (w_last) begin
                     r_line_valid <= ~w_err_any & ~r_inv_pending & ~invalidate_i
                                     & enable_i & ~r_pass;
                     r_tag        <= r_req_tag;
                     r_rdata      <= w_fill_word;
                     r_rresp      <= w_err_any ? RESP_SLVERR : RESP_OKAY;
                     r_rvalid     <= 1'b1;
                  end else begin
                     r_beat <= r_beat + IDX_W'(1);
                  end
               end
            end
            ST_RESP: begin
               if (invalidate_i) r_line_valid <= 1'b0;
               if (s_rready_i)   r_rvalid     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
